if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage for the RISC-V pipeline. It drives a synchronous-read instruction memory and buffers fetched {PC, instruction} pairs in a prefetch FIFO. ID consumes entries through a valid/ready handshake. A branch/jump redirect flushes the queue, discards any in-flight response and refetches from the target. It sits between the PC source (EX branch/jump resolution) and the IF/ID register.

Parameters:
XLEN, 32, width of PC and instruction words
IMEM_AW, 6, word-address width of instruction memory (2^IMEM_AW words)
FQ_DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, PC fetched first after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
redirect_valid  in  1  branch taken or jump this cycle
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
imem_en  out  1  memory read strobe
imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
imem_rdata  in  XLEN  read data, valid exactly 1 cycle after imem_en
out_valid  out  1  head entry available to ID
out_ready  in  1  ID accepts head entry
out_pc  out  XLEN  PC of head entry
out_instr  out  XLEN  instruction of head entry
if_flush  out  1  flush request to IF/ID; equals redirect_valid (combinational)
fq_count  out  clog2(FQ_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (clk edge with reset=1): fetch_pc=RESET_PC; FIFO empty; fq_count=0; in-flight flag=0; kill flag=0. Outputs while reset is held: out_valid=0, imem_en=0. Reset mid-operation discards everything, including any in-flight response.
- Issue rule (no redirect): imem_en=1 iff fq_count + inflight < FQ_DEPTH. On issue, imem_addr=fetch_pc[IMEM_AW+1:2]; the register pc_q holds the issued PC for one cycle; fetch_pc<=fetch_pc+4.
- fetch_pc arithmetic is modulo 2^XLEN (wraps). imem_addr is a truncation of the PC, so the memory index wraps at 2^IMEM_AW words.
- Response: in the cycle after an issue, if the kill flag is clear, {pc_q, imem_rdata} is pushed into the FIFO. The credit rule guarantees the FIFO never overflows.
- Pop: when out_valid && out_ready, the head entry is removed. Push and pop may occur in the same cycle; fq_count is then unchanged.
- out_valid = (fq_count != 0) && !redirect_valid. out_pc and out_instr come from the FIFO head register; they are don't-care when out_valid=0.
- Redirect cycle N:
  - FIFO is cleared; pops are ignored.
  - A response arriving in cycle N is dropped.
  - Any issue from cycle N-1 is killed.
  - imem_en=1 with imem_addr=redirect_pc[IMEM_AW+1:2] (fetch at target in the same cycle); fetch_pc<=redirect_pc+4; pc_q<=redirect_pc with {1:0}=0.
  - The target instruction is pushed in cycle N+1 and becomes visible with out_valid=1 in cycle N+2 (2-cycle redirect latency).
- Back-to-back redirects: the later one wins. Each one cancels the earlier target fetch.
- Stall: with out_ready=0, the FIFO fills to FQ_DEPTH and then issue stops (imem_en=0). No entry is lost or duplicated. Fetch resumes the cycle after a pop frees a credit.
- Throughput: with out_ready held at 1, the block sustains 1 instruction/cycle after the initial 2-cycle fill.
- Ordering: entries leave in strict PC-sequence order between redirects.

Test Plan:
- Reset, RESET_PC=0, ROM[i]=i, out_ready=1 -> out_valid first high 2 cycles after reset release; out_pc 0,4,8,... with out_instr 0,1,2,... on consecutive cycles.
- out_ready=0 for 10 cycles -> fq_count saturates at 4; imem_en=0 once in-flight=0; release gives PCs 0,4,8,12,16 with no gaps or repeats.
- Redirect_valid=1, redirect_pc=0x40 while FIFO holds 3 entries -> if_flush=1 and out_valid=0 that cycle; fq_count=0 next cycle; next delivered out_pc=0x40 two cycles later, instr=ROM[16].
- Redirect on consecutive cycles to 0x20 then 0x80 -> no 0x20 entry is ever delivered; first output is 0x80.
- redirect_pc=0x103 with IMEM_AW=6 -> out_pc=0x100; imem_addr=0 (wrap); then 0x104 with addr 1.
- Reset asserted while FIFO full and a fetch is in flight -> next cycle fq_count=0 and out_valid=0; after release, the first output is out_pc=RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: drives a synchronous-read instruction memory and buffers
// {PC, instruction} pairs in a prefetch FIFO consumed by ID over valid/ready.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              IMEM_AW  = 6,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          imem_en,
    output logic [IMEM_AW-1:0]            imem_addr,
    input  logic [XLEN-1:0]               imem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_pc,
    output logic [XLEN-1:0]               out_instr,
    output logic                          if_flush,
    output logic [$clog2(FQ_DEPTH):0]     fq_count
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_q;
    logic            inflight;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] fifo_pc    [FQ_DEPTH];
    logic [XLEN-1:0] fifo_instr [FQ_DEPTH];

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] issue_pc;
    logic            credit;
    logic            issue;
    logic            push;
    logic            pop;

    assign target   = redirect_pc & ~(XLEN'(3));
    assign issue_pc = redirect_valid ? target : fetch_pc;

    // A slot is reserved for every outstanding read, so a response can never find the FIFO full.
    assign credit   = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(FQ_DEPTH);
    assign issue    = !reset && (redirect_valid || credit);

    assign imem_en   = issue;
    assign imem_addr = issue_pc[IMEM_AW+1:2];

    // A response landing in a redirect cycle belongs to the abandoned path.
    assign push      = inflight && !redirect_valid;
    assign out_valid = !reset && !redirect_valid && (count != '0);
    assign pop       = out_valid && out_ready;

    assign out_pc    = fifo_pc[rd_ptr];
    assign out_instr = fifo_instr[rd_ptr];
    assign if_flush  = redirect_valid;
    assign fq_count  = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            pc_q     <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc_q     <= issue_pc;
                fetch_pc <= issue_pc + XLEN'(4);
            end
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_pc[wr_ptr]    <= pc_q;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based fetch model checked every cycle, plus
// hand-computed expectations for reset, stall, redirect, wrap and mid-run reset.
module tb_if_fetch_queue;

    localparam int          XLEN   = 32;
    localparam int          AW     = 6;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              redirect_valid = 1'b0;
    logic [XLEN-1:0]   redirect_pc = '0;
    logic              imem_en;
    logic [AW-1:0]     imem_addr;
    logic [XLEN-1:0]   imem_rdata;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_instr;
    logic              if_flush;
    logic [2:0]        fq_count;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rom [64];

    logic [31:0] q_pc [$];
    bit          pend_v = 1'b0;
    logic [31:0] pend_pc = '0;
    logic [31:0] npc = '0;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .XLEN(XLEN), .IMEM_AW(AW), .FQ_DEPTH(DEPTH), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .if_flush(if_flush), .fq_count(fq_count)
    );

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = i;
    end

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= rom[imem_addr];
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
    endtask

    // Model: FIFO contents as a queue of PCs, one optional outstanding read, next sequential PC.
    always @(negedge clk) begin
        bit          exp_valid;
        bit          exp_en;
        logic [31:0] exp_addr_pc;
        logic [31:0] tgt;
        #2;
        tgt = redirect_pc & ~32'd3;
        check_output("if_flush", {31'b0, if_flush}, {31'b0, redirect_valid});
        if (reset) begin
            check_output("rst_en", {31'b0, imem_en}, 32'd0);
            check_output("rst_valid", {31'b0, out_valid}, 32'd0);
            q_pc.delete();
            pend_v = 1'b0;
            npc    = RST_PC;
        end else begin
            exp_valid   = !redirect_valid && (q_pc.size() != 0);
            exp_en      = redirect_valid || ((q_pc.size() + int'(pend_v)) < DEPTH);
            exp_addr_pc = redirect_valid ? tgt : npc;
            check_output("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
            check_output("fq_count", {29'b0, fq_count}, 32'(q_pc.size()));
            check_output("imem_en", {31'b0, imem_en}, {31'b0, exp_en});
            if (exp_en) check_output("imem_addr", {26'b0, imem_addr}, {26'b0, exp_addr_pc[7:2]});
            if (exp_valid) begin
                check_output("out_pc", out_pc, q_pc[0]);
                check_output("out_instr", out_instr, rom[q_pc[0][7:2]]);
            end
            if (redirect_valid) begin
                q_pc.delete();
                pend_v  = 1'b1;
                pend_pc = tgt;
                npc     = tgt + 32'd4;
            end else begin
                if (exp_valid && out_ready) void'(q_pc.pop_front());
                if (pend_v) q_pc.push_back(pend_pc);
                if (exp_en) begin
                    pend_v  = 1'b1;
                    pend_pc = npc;
                    npc     = npc + 32'd4;
                end else begin
                    pend_v = 1'b0;
                end
            end
        end
    end

    initial begin
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);

        // Cold start: two idle cycles, then one instruction per cycle.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
            #3;
            if (i == 0) begin
                check_output("lit_first_en", {31'b0, imem_en}, 32'd1);
                check_output("lit_first_addr", {26'b0, imem_addr}, 32'd0);
            end
            if (i < 2) begin
                check_output("lit_fill_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                check_output("lit_stream_valid", {31'b0, out_valid}, 32'd1);
                check_output("lit_stream_pc", out_pc, 32'((i - 2) * 4));
                check_output("lit_stream_instr", out_instr, 32'(i - 2));
            end
        end

        // Stall: FIFO saturates, issue stops.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
            #3;
            if (i == 9) begin
                check_output("lit_stall_count", {29'b0, fq_count}, 32'd4);
                check_output("lit_stall_en", {31'b0, imem_en}, 32'd0);
            end
        end
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
            #3;
            check_output("lit_drain_valid", {31'b0, out_valid}, 32'd1);
            check_output("lit_drain_pc", out_pc, 32'(24 + 4 * k));
            check_output("lit_drain_instr", out_instr, 32'(6 + k));
            if (k == 0) check_output("lit_drain_noissue", {31'b0, imem_en}, 32'd0);
            if (k == 1) check_output("lit_resume_addr", {26'b0, imem_addr}, 32'd10);
        end

        // Redirect with entries buffered.
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h40, 1'b1);
        #3;
        check_output("lit_redir_flush", {31'b0, if_flush}, 32'd1);
        check_output("lit_redir_valid", {31'b0, out_valid}, 32'd0);
        check_output("lit_redir_addr", {26'b0, imem_addr}, 32'd16);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_redir_count", {29'b0, fq_count}, 32'd0);
        check_output("lit_redir_n1_valid", {31'b0, out_valid}, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_redir_n2_valid", {31'b0, out_valid}, 32'd1);
        check_output("lit_redir_pc", out_pc, 32'h40);
        check_output("lit_redir_instr", out_instr, 32'd16);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_redir_next_pc", out_pc, 32'h44);

        // Back-to-back redirects: only the second target survives.
        apply_stimulus(1'b0, 1'b1, 32'h20, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h80, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_b2b_gap", {31'b0, out_valid}, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_b2b_pc", out_pc, 32'h80);
        check_output("lit_b2b_instr", out_instr, 32'd32);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Misaligned target and memory-index wrap.
        apply_stimulus(1'b0, 1'b1, 32'h103, 1'b1);
        #3;
        check_output("lit_wrap_addr0", {26'b0, imem_addr}, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_wrap_addr1", {26'b0, imem_addr}, 32'd1);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_wrap_pc", out_pc, 32'h100);
        check_output("lit_wrap_instr", out_instr, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_wrap_pc2", out_pc, 32'h104);
        check_output("lit_wrap_instr2", out_instr, 32'd1);

        // PC arithmetic wraps at the top of the address space.
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_top_pc", out_pc, 32'hFFFF_FFFC);
        check_output("lit_top_instr", out_instr, 32'd63);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_top_wrap_pc", out_pc, 32'h0);

        // Reset while entries are buffered and a read is outstanding.
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #3;
        check_output("lit_rst_valid", {31'b0, out_valid}, 32'd0);
        check_output("lit_rst_en", {31'b0, imem_en}, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_rst_count", {29'b0, fq_count}, 32'd0);
        check_output("lit_rst_after_valid", {31'b0, out_valid}, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        check_output("lit_rst_first_pc", out_pc, RST_PC);
        check_output("lit_rst_first_instr", out_instr, 32'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
